// File: rtl/out_uart_tx.sv
// out_uart_tx: buffers bytes from the CPU output register in a small FIFO and
// serializes each one as UART 8N1 (start, 8 data bits LSB first, stop).
//
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous active-low reset
//   out_data  byte from the CPU output register
//   out_we    one-cycle write strobe per OI instruction
//   tx        UART serial line, idles high
//   busy      frame in flight or FIFO non-empty
//   full      FIFO holds 2**FIFO_AW entries
//   level     FIFO occupancy, 0..2**FIFO_AW
//   overflow  sticky: a write was dropped because the FIFO was full
module out_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_AW      = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         out_data,
  input  logic               out_we,
  output logic               tx,
  output logic               busy,
  output logic               full,
  output logic [FIFO_AW:0]   level,
  output logic               overflow
);

  localparam int unsigned DEPTH = 1 << FIFO_AW;
  localparam int unsigned LW    = FIFO_AW + 1;
  localparam int unsigned TW    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] T_LAST   = TW'(CLKS_PER_BIT - 1);
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t               r_state, w_state_next;
  logic [TW-1:0]        r_timer, w_timer_next;
  logic [2:0]           r_bit_idx, w_bit_idx_next;
  logic [7:0]           r_shift, w_shift_next;
  logic [7:0]           r_mem [DEPTH];
  logic [FIFO_AW-1:0]   r_wr_ptr, r_rd_ptr;
  logic [LW-1:0]        r_level, w_level_next;
  logic                 r_tx, w_tx_next;
  logic                 r_busy, r_full, r_overflow;
  logic                 w_bit_end, w_pop, w_push, w_drop, w_full_now;

  assign w_bit_end  = (r_timer == T_LAST);
  assign w_full_now = (r_level == LVL_FULL);

  // A pop frees a slot in the same cycle, so a write on a pop edge is never dropped
  assign w_push = out_we & (~w_full_now | w_pop);
  assign w_drop = out_we & w_full_now & ~w_pop;
  assign w_level_next = r_level + LW'(w_push) - LW'(w_pop);

  // Next-state, pop and serializer logic
  always_comb begin
    w_state_next   = r_state;
    w_timer_next   = w_bit_end ? '0 : r_timer + TW'(1);
    w_bit_idx_next = r_bit_idx;
    w_shift_next   = r_shift;
    w_pop          = 1'b0;
    w_tx_next      = 1'b1;

    unique case (r_state)
      S_IDLE: begin
        w_timer_next = '0;
        if (r_level != '0) begin
          w_pop        = 1'b1;
          w_shift_next = r_mem[r_rd_ptr];
          w_state_next = S_START;
        end
      end
      S_START: begin
        if (w_bit_end) begin
          w_state_next   = S_DATA;
          w_bit_idx_next = '0;
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          w_shift_next = r_shift >> 1;
          if (r_bit_idx == 3'd7) begin
            w_state_next = S_STOP;
          end else begin
            w_bit_idx_next = r_bit_idx + 3'(1);
          end
        end
      end
      S_STOP: begin
        if (w_bit_end) begin
          // Chain straight into the next start bit to keep frames contiguous
          if (r_level != '0) begin
            w_pop        = 1'b1;
            w_shift_next = r_mem[r_rd_ptr];
            w_state_next = S_START;
          end else begin
            w_state_next = S_IDLE;
          end
        end
      end
      default: w_state_next = S_IDLE;
    endcase

    // tx is registered from the next state so it changes on the same edge as the FSM
    unique case (w_state_next)
      S_START: w_tx_next = 1'b0;
      S_DATA:  w_tx_next = w_shift_next[0];
      default: w_tx_next = 1'b1;
    endcase
  end

  // FSM, serializer and status registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_timer    <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
      r_full     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_timer   <= w_timer_next;
      r_bit_idx <= w_bit_idx_next;
      r_shift   <= w_shift_next;
      r_level   <= w_level_next;
      r_tx      <= w_tx_next;
      r_busy    <= (w_state_next != S_IDLE) || (w_level_next != '0);
      r_full    <= (w_level_next == LVL_FULL);
      if (w_push) r_wr_ptr <= r_wr_ptr + FIFO_AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + FIFO_AW'(1);
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  // FIFO storage; no reset needed since level gates every read
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= out_data;
  end

  assign tx       = r_tx;
  assign busy     = r_busy;
  assign full     = r_full;
  assign level    = r_level;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_out_uart_tx.sv
// tb_out_uart_tx: randomized bench for out_uart_tx with a frame-level reference
// model, a scoreboard of accepted bytes, and a UART receiver monitor.
module tb_out_uart_tx;

  localparam int unsigned C     = 4;
  localparam int unsigned AW    = 2;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned FRAME = 10 * C;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    out_data = 8'h00;
  logic          out_we = 1'b0;
  logic          tx, busy, full, overflow;
  logic [AW:0]   level;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state: FIFO contents, cycles left in the current frame, byte on the wire
  logic [7:0] m_fifo[$];
  logic [7:0] exp_q[$];
  int         m_rem = 0;
  logic [7:0] m_cur = 8'h00;
  bit         m_ovf = 1'b0;

  always #5 clk = ~clk;

  out_uart_tx #(.CLKS_PER_BIT(C), .FIFO_AW(AW)) dut (
    .clk(clk), .rst(rst), .out_data(out_data), .out_we(out_we),
    .tx(tx), .busy(busy), .full(full), .level(level), .overflow(overflow)
  );

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Line level implied by the frame position: start bit, 8 data bits LSB first, stop bit
  function automatic int model_tx();
    int idx;
    if (m_rem == 0) return 1;
    idx = (FRAME - m_rem) / C;
    if (idx == 0) return 0;
    if (idx <= 8) return int'(m_cur[idx-1]);
    return 1;
  endfunction

  // Reference model: one update per clock edge
  initial begin
    forever begin
      bit pop, drop;
      @(posedge clk or negedge rst);
      if (!rst) begin
        m_fifo.delete();
        exp_q.delete();
        m_rem = 0;
        m_ovf = 1'b0;
      end else begin
        pop  = (m_fifo.size() > 0) && (m_rem <= 1);
        drop = out_we && (m_fifo.size() == DEPTH) && !pop;
        if (pop) begin
          m_cur = m_fifo.pop_front();
          m_rem = FRAME;
        end else if (m_rem > 0) begin
          m_rem--;
        end
        if (out_we) begin
          if (drop) m_ovf = 1'b1;
          else begin
            m_fifo.push_back(out_data);
            exp_q.push_back(out_data);
          end
        end
      end
    end
  end

  // Monitor: per-cycle status checks plus a UART receiver feeding the scoreboard
  initial begin
    bit         rx_active;
    int         rx_cnt;
    logic [7:0] rx_byte;
    logic [7:0] e;
    int         k;
    rx_active = 1'b0;
    rx_cnt    = 0;
    rx_byte   = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst) begin
        rx_active = 1'b0;
        rx_cnt    = 0;
      end else begin
        check("tx_line", int'(tx), model_tx());
        check("busy", int'(busy), int'((m_rem > 0) || (m_fifo.size() > 0)));
        check("level", int'(level), m_fifo.size());
        check("full", int'(full), int'(m_fifo.size() == DEPTH));
        check("overflow", int'(overflow), int'(m_ovf));

        if (!rx_active && tx == 1'b0) begin
          rx_active = 1'b1;
          rx_cnt    = 0;
        end
        if (rx_active) begin
          if (rx_cnt % C == C / 2) begin
            k = rx_cnt / C;
            if (k == 0) check("rx_start_bit", int'(tx), 0);
            else if (k <= 8) rx_byte[k-1] = tx;
            else begin
              check("rx_stop_bit", int'(tx), 1);
              if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL rx_unexpected: got byte %02h expected none at %0t", rx_byte, $time);
              end else begin
                e = exp_q.pop_front();
                check("rx_byte", int'(rx_byte), int'(e));
              end
            end
          end
          if (rx_cnt == FRAME - 1) rx_active = 1'b0;
          else rx_cnt++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [7:0] d);
    out_we   = 1'b1;
    out_data = d;
    tick();
    out_we   = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((busy || level != '0) && n < 400) begin
      tick();
      n++;
    end
    check(name, int'(busy), 0);
  endtask

  task automatic do_reset();
    #2 rst = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
  endtask

  // Stimulus
  initial begin
    int n;
    int peak;

    // Reset state
    #2 rst = 1'b0;
    repeat (3) tick();
    check("rst_tx", int'(tx), 1);
    check("rst_level", int'(level), 0);
    rst = 1'b1;
    tick();
    check("rst_busy", int'(busy), 0);
    check("rst_overflow", int'(overflow), 0);
    check("rst_full", int'(full), 0);

    // Single byte: start bit one edge after the write, 40-cycle frame
    write(8'hA5);
    check("a5_level", int'(level), 1);
    tick();
    check("a5_start", int'(tx), 0);
    n = 0;
    while (busy && n < 200) begin
      tick();
      n++;
    end
    check("a5_frame_len", n, FRAME);
    check("a5_tx_idle", int'(tx), 1);

    // Back-to-back: three contiguous frames
    peak = 0;
    out_we = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      out_data = 8'(i);
      tick();
      if (int'(level) > peak) peak = int'(level);
    end
    out_we = 1'b0;
    n = 0;
    while (busy && n < 400) begin
      tick();
      n++;
      if (int'(level) > peak) peak = int'(level);
    end
    check("b2b_peak_level", peak, 2);
    check("b2b_total_len", n + 1, 3 * FRAME);

    // Overflow: six consecutive writes, the sixth is dropped
    out_we = 1'b1;
    for (int i = 0; i < 6; i++) begin
      out_data = 8'h10 + 8'(i);
      tick();
    end
    out_we = 1'b0;
    check("ovf_set", int'(overflow), 1);
    check("ovf_full", int'(full), 1);
    drain("ovf_drain");
    check("ovf_sticky", int'(overflow), 1);

    // Reset mid-frame while a zero data bit is on the line
    write(8'h00);
    write(8'h77);
    repeat (6) tick();
    #2 rst = 1'b0;
    #1;
    check("midrst_tx", int'(tx), 1);
    check("midrst_level", int'(level), 0);
    check("midrst_overflow", int'(overflow), 0);
    repeat (2) tick();
    rst = 1'b1;
    tick();

    // Push on the exact edge that STOP pops while full
    write(8'hC0);
    for (int i = 1; i <= 4; i++) write(8'hC0 + 8'(i));
    check("pp_full_before", int'(level), 4);
    n = 0;
    while (m_rem != 1 && n < 200) begin
      tick();
      n++;
    end
    check("pp_reached_stop_end", m_rem, 1);
    write(8'hC5);
    check("pp_level", int'(level), 4);
    check("pp_overflow", int'(overflow), 0);
    drain("pp_drain");

    // Wrap-around: ten bytes with random gaps
    for (int i = 0; i < 10; i++) begin
      write(8'h30 + 8'(i));
      repeat ($urandom_range(0, 60)) tick();
    end
    drain("wrap_drain");
    check("wrap_level", int'(level), 0);

    // Random traffic, including bursts that overflow
    do_reset();
    for (int i = 0; i < 600; i++) begin
      out_we   = ($urandom_range(0, 15) == 0);
      out_data = 8'($urandom_range(0, 255));
      tick();
    end
    out_we = 1'b0;
    drain("rand_drain");
    tick();
    check("sb_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish by %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/out_uart_tx.md
Name: out_uart_tx

Overview:
- Downstream consumer of the CPU output register. Captures each byte the CPU writes on an output instruction (OI strobe with OutPut data) into a small FIFO.
- Serializes each captured byte as UART 8N1 on a single tx line, so program results can be logged off-chip alongside the seven-segment display.
- Sits beside the display decoders at the top level, in the same clk domain as the CPU.

Parameters:
- CLKS_PER_BIT, 16, clk cycles per UART bit; legal range is 2 or more.
- FIFO_AW, 2, FIFO address width; depth = 2**FIFO_AW (default 4 entries).

Ports:
- clk  input  1  system clock, rising-edge active; the same gated clk that drives the CPU registers.
- rst  input  1  asynchronous, active-low reset.
- out_data  input  8  byte from the CPU output register.
- out_we  input  1  write strobe, one cycle per OI instruction; sampled on the rising edge of clk.
- tx  output  1  UART serial line; idles high.
- busy  output  1  high while a frame is in flight or the FIFO is non-empty.
- full  output  1  FIFO holds 2**FIFO_AW entries.
- level  output  FIFO_AW+1  current FIFO occupancy, 0..2**FIFO_AW.
- overflow  output  1  sticky flag; set when a write is dropped.

Behaviour:
- Reset (rst low, asynchronous): tx=1, busy=0, full=0, level=0, overflow=0, FSM=IDLE, FIFO pointers and bit timer cleared.
  - Reset asserted mid-frame aborts the frame immediately; tx returns high without waiting for a clock.
- FIFO:
  - out_we=1 and not full at an edge: out_data is written and level increments.
  - out_we=1 and full, with no pop in the same cycle: the byte is dropped, level is unchanged, and overflow is set. overflow stays set until reset.
  - Push and pop in the same cycle: both take effect, level is unchanged, no drop. This holds even when full.
  - Pointers wrap modulo 2**FIFO_AW.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If the FIFO is non-empty at an edge, pop the head into an 8-bit shift register, clear the bit timer, and go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: tx = shift register bit 0, sent LSB first. Hold each bit for CLKS_PER_BIT cycles, then shift right. After bit 7, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. At its last cycle:
    - if the FIFO is non-empty, pop the next byte and go directly to START, with no extra idle cycle;
    - otherwise go to IDLE.
- Bit timer counts 0..CLKS_PER_BIT-1. The state or bit advances on the edge where the timer equals CLKS_PER_BIT-1.
- Timing:
  - A byte written at edge N into an empty, idle block is popped at edge N+1. tx falls after edge N+1.
  - Frame length is exactly 10*CLKS_PER_BIT cycles.
  - Back-to-back frames are contiguous.
- busy = (FSM != IDLE) or (level != 0).
- tx is a registered output with no combinational path from out_data or out_we.
- No flow control back to the CPU. The CPU never stalls; excess bytes are dropped and flagged via overflow.
- HLT gating of clk freezes the block. Firmware must allow frames to drain before halting; the block provides no mechanism for this.

Test Plan (CLKS_PER_BIT=4, FIFO_AW=2):
- Reset: hold rst low for 3 cycles, then release -> tx=1, busy=0, level=0, overflow=0. Pull rst low mid-frame -> tx=1 immediately, level=0.
- Single byte: pulse out_we with out_data=0xA5 -> tx falls one edge later, then emits 0,1,0,1,0,0,1,0,1,1 at 4 cycles per bit (40 cycles total), then busy=0.
- Back-to-back: write 0x01, 0x02, 0x03 on consecutive cycles -> level peaks at 2, three contiguous frames totalling 120 cycles, no high gap between a stop bit and the next start bit.
- Overflow: write 6 bytes 0x10..0x15 on consecutive cycles -> 0x10..0x14 are transmitted, 0x15 is dropped, overflow=1 and remains 1 after the FIFO drains.
  - Here 0x10 is popped at the 2nd edge, so 4 are held plus 1 in flight.
- Push and pop together when full: fill the FIFO while a frame is on the wire, then assert out_we on the exact edge STOP pops -> level stays 4 and overflow stays 0.
- Wrap-around: transmit 10 single bytes 0x30..0x39 with gaps -> all received in order, pointers wrap cleanly, level returns to 0.
